rx_link_assembler: RTL and testbench

- Receive-side unit directly upstream of the router core's RX handshake stage.
- Assembles byte-wide link traffic into fixed-size packets and holds one completed packet in a holding register.
- Offers each held packet on RX_Data with RX_Data_Valid, and completes the transfer using the core's Ready-high-then-low acknowledge protocol.
- A second packet can be assembled while the first awaits handoff (one assembly register plus one holding register).

---
 rtl/rx_pkg.sv | 14 +
 rtl/rx_link_assembler_if.sv | 27 ++
 rtl/rx_sat_counter.sv | 20 ++
 rtl/rx_link_assembler.sv | 162 ++++++++++++++++
 tb/tb_rx_link_assembler.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the RX link assembler: output FSM states and
// default sizing constants.
package rx_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    OFFER = 2'd1,
    ARMED = 2'd2
  } rx_state_t;

  localparam int unsigned PKT_BYTES_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 8;

endpackage

// File: rtl/rx_link_assembler_if.sv
// Link-side byte stream and core-side RX handshake bundle.
// master: the assembler (drives RX_Data/RX_Data_Valid).
// slave:  the environment (link source and router core).
interface rx_link_assembler_if
  import rx_pkg::*;
#(
  parameter int unsigned PKT_BYTES = PKT_BYTES_DEF
);

  logic                   link_valid;
  logic                   link_sop;
  logic [7:0]             link_data;
  logic [8*PKT_BYTES-1:0] RX_Data;
  logic                   RX_Data_Valid;
  logic                   RX_Data_Ready;

  modport master (
    input  link_valid, link_sop, link_data, RX_Data_Ready,
    output RX_Data, RX_Data_Valid
  );

  modport slave (
    output link_valid, link_sop, link_data, RX_Data_Ready,
    input  RX_Data, RX_Data_Valid
  );

endinterface

// File: rtl/rx_sat_counter.sv
// Saturating event counter: sticks at all-ones.
module rx_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on event unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/rx_link_assembler.sv
// RX link assembler: packs link bytes into PKT_BYTES-wide packets, keeps one
// completed packet in a holding register and offers it to the router core
// with a Ready-high-then-low acknowledge.
// Optional feature macro: RX_CHKSUM_EN (XOR checksum in final byte, adds chk_cnt).
module rx_link_assembler
  import rx_pkg::*;
#(
  parameter int unsigned PKT_BYTES = PKT_BYTES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rx_link_assembler_if.master  bus,
  output logic [CNT_W-1:0]     ovf_cnt,
  output logic [CNT_W-1:0]     frm_cnt,
  output logic                 busy
`ifdef RX_CHKSUM_EN
  ,
  output logic [CNT_W-1:0]     chk_cnt
`endif
);

  localparam int unsigned CW = $clog2(PKT_BYTES);
  localparam int unsigned AW = 8 * (PKT_BYTES - 1);
  localparam int unsigned DW = 8 * PKT_BYTES;

  logic [CW-1:0] cnt_q;
  logic [AW-1:0] asm_q;
  logic [DW-1:0] hold_q;
  logic [DW-1:0] pkt;
  logic          start;
  logic          frm_err;
  logic          complete;
  logic          good;
  logic          release_ack;
  logic          accept;
  logic          drop;
  rx_state_t     state_q;
  rx_state_t     state_d;
  logic          valid_d;
  logic          load_out;
`ifdef RX_CHKSUM_EN
  logic [7:0]    sum;
`endif

  // Decode link events and decide the fate of a completing packet.
  always_comb begin
    start       = bus.link_valid & bus.link_sop;
    frm_err     = start & (cnt_q != '0);
    complete    = bus.link_valid & ~bus.link_sop & (cnt_q == CW'(PKT_BYTES - 1));
    pkt         = {asm_q, bus.link_data};
`ifdef RX_CHKSUM_EN
    sum = '0;
    for (int unsigned i = 0; i < PKT_BYTES - 1; i++) begin
      sum = sum ^ asm_q[i*8 +: 8];
    end
    good = (sum == bus.link_data);
`else
    good = 1'b1;
`endif
    release_ack = (state_q == ARMED) & ~bus.RX_Data_Ready;
    accept      = complete & good & ((state_q == EMPTY) | release_ack);
    drop        = complete & good & ~accept;
  end

  // Byte counter and assembly shift register (first byte ends up in MSBs).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (start) begin
      cnt_q <= CW'(1);
      asm_q <= AW'(bus.link_data);
    end else if (bus.link_valid && (cnt_q != '0)) begin
      cnt_q <= complete ? '0 : cnt_q + CW'(1);
      asm_q <= AW'({asm_q, bus.link_data});
    end
  end

  // Holding register: written only when empty or released this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (accept) begin
      hold_q <= pkt;
    end
  end

  // Output FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= EMPTY;
      bus.RX_Data_Valid <= 1'b0;
      bus.RX_Data       <= '0;
    end else begin
      state_q           <= state_d;
      bus.RX_Data_Valid <= valid_d;
      if (load_out) begin
        bus.RX_Data <= hold_q;
      end
    end
  end

  // Next-state and output decode. OFFER is entered with Valid still low;
  // its first cycle raises Valid and loads RX_Data, which yields the one-cycle
  // latency and the mandatory low gap after an ack. Ready is only sampled
  // as an arm once Valid is actually high.
  always_comb begin
    state_d  = state_q;
    valid_d  = bus.RX_Data_Valid;
    load_out = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = OFFER;
      end
      OFFER: begin
        if (!bus.RX_Data_Valid) begin
          valid_d  = 1'b1;
          load_out = 1'b1;
        end else if (bus.RX_Data_Ready) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (release_ack) begin
          valid_d = 1'b0;
          state_d = accept ? OFFER : EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
        valid_d = 1'b0;
      end
    endcase
  end

  assign busy = (cnt_q != '0) | (state_q != EMPTY);

  rx_sat_counter #(.W(CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop),
    .count (ovf_cnt)
  );

  rx_sat_counter #(.W(CNT_W)) u_frm_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frm_err),
    .count (frm_cnt)
  );

`ifdef RX_CHKSUM_EN
  rx_sat_counter #(.W(CNT_W)) u_chk_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (complete & ~good),
    .count (chk_cnt)
  );
`endif

endmodule

// File: tb/tb_rx_link_assembler.sv
// Scoreboard bench for rx_link_assembler: directed scenarios plus randomized
// link/core traffic, checked against a packet-level reference model.
module tb_rx_link_assembler;

  localparam int PB = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_link_assembler_if #(.PKT_BYTES(PB)) bus ();

  logic [CW-1:0] ovf_cnt;
  logic [CW-1:0] frm_cnt;
  logic          busy;
`ifdef RX_CHKSUM_EN
  logic [CW-1:0] chk_cnt;
`endif

  rx_link_assembler #(.PKT_BYTES(PB), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ovf_cnt (ovf_cnt),
    .frm_cnt (frm_cnt),
    .busy    (busy)
`ifdef RX_CHKSUM_EN
    ,
    .chk_cnt (chk_cnt)
`endif
  );

  // Reference model state
  logic [7:0]      m_bytes[$];
  logic [8*PB-1:0] exp_q[$];
  bit m_full, m_valid, m_armed, m_pend;
  int m_ovf, m_frm, m_chk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_bytes.delete();
    exp_q.delete();
    m_full = 0; m_valid = 0; m_armed = 0; m_pend = 0;
    m_ovf = 0; m_frm = 0; m_chk = 0;
  endtask

  // One clock edge of the packet-level model
  task automatic model_edge();
    bit ack, arm, cpl, ok;
    logic [8*PB-1:0] p;
    logic [7:0] x;
    ack = m_armed && !bus.RX_Data_Ready;
    arm = m_valid && !m_armed && bus.RX_Data_Ready;
    cpl = 0; ok = 1; p = '0; x = '0;
    if (bus.link_valid) begin
      if (bus.link_sop) begin
        if (m_bytes.size() != 0) m_frm = sat(m_frm + 1);
        m_bytes.delete();
        m_bytes.push_back(bus.link_data);
      end else if (m_bytes.size() != 0) begin
        m_bytes.push_back(bus.link_data);
        if (m_bytes.size() == PB) begin
          cpl = 1;
          for (int i = 0; i < PB; i++) p = (p << 8) | {{(8*PB-8){1'b0}}, m_bytes[i]};
          for (int i = 0; i < PB - 1; i++) x = x ^ m_bytes[i];
`ifdef RX_CHKSUM_EN
          ok = (x == m_bytes[PB-1]);
`endif
          m_bytes.delete();
        end
      end
    end
    if (ack) begin
      m_valid = 0; m_armed = 0; m_full = 0;
    end else if (arm) begin
      m_armed = 1;
    end
    if (m_pend) begin
      m_valid = 1; m_pend = 0;
    end
    if (cpl) begin
      if (!ok) m_chk = sat(m_chk + 1);
      else if (!m_full) begin
        exp_q.push_back(p);
        m_full = 1; m_pend = 1;
      end else m_ovf = sat(m_ovf + 1);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // Monitor: compares DUT outputs with the model every cycle, pops the
  // scoreboard whenever the DUT starts a new offer.
  initial begin
    bit prev_v;
    logic [8*PB-1:0] last_d, e;
    prev_v = 0; last_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 0; last_d = '0;
      end
      chk("valid", bus.RX_Data_Valid, m_valid);
      if (bus.RX_Data_Valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_offer: got %h expected no offer at %0t", bus.RX_Data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", bus.RX_Data, e);
          last_d = e;
        end
      end else begin
        chk("rx_data_hold", bus.RX_Data, last_d);
      end
      chk("ovf_cnt", ovf_cnt, m_ovf);
      chk("frm_cnt", frm_cnt, m_frm);
      chk("busy", busy, (m_bytes.size() != 0) || m_full);
`ifdef RX_CHKSUM_EN
      chk("chk_cnt", chk_cnt, m_chk);
`endif
      prev_v = bus.RX_Data_Valid;
    end
  end

  task automatic step(input bit v, input bit s, input logic [7:0] d, input bit r);
    @(negedge clk);
    bus.link_valid    = v;
    bus.link_sop      = s;
    bus.link_data     = d;
    bus.RX_Data_Ready = r;
  endtask

  task automatic send(input logic [31:0] w, input bit r);
    for (int i = 0; i < PB; i++) step(1'b1, i == 0, w[31-8*i -: 8], r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, r);
  endtask

  task automatic ack();
    idle(2, 1'b1);
    idle(2, 1'b0);
  endtask

  task automatic rand_phase(input int n, input int p_ready);
    bit v, s, r;
    logic [7:0] d, x;
    for (int k = 0; k < n; k++) begin
      v = ($urandom_range(0, 99) < 70);
      s = (m_bytes.size() == 0) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 4);
      d = 8'($urandom);
      if (v && !s && (m_bytes.size() == PB - 1) && ($urandom_range(0, 9) < 8)) begin
        x = '0;
        for (int i = 0; i < PB - 1; i++) x = x ^ m_bytes[i];
        d = x;
      end
      r = ($urandom_range(0, 99) < p_ready);
      step(v, s, d, r);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.link_valid = 0; bus.link_sop = 0; bus.link_data = '0; bus.RX_Data_Ready = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset_valid", bus.RX_Data_Valid, 0);
    chk("reset_data", bus.RX_Data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ovf", ovf_cnt, 0);
    chk("reset_frm", frm_cnt, 0);
    rst_n = 1;

    // Basic packet, Ready high then low
    send(32'hA1B2C3D4, 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b1);
    idle(3, 1'b0);

    // Ready held low: no ack, stable offer
    send(32'h5A6B7C8D, 1'b0);
    idle(50, 1'b0);
    ack();

    // Back-to-back packets with core stalled
    send(32'h01234567, 1'b0);
    send(32'h89ABCDEF, 1'b0);
    send(32'h0F1E2D3C, 1'b0);
    idle(3, 1'b0);
    ack();

    // Framing error followed by a clean packet
    step(1'b1, 1'b1, 8'h55, 1'b0);
    step(1'b1, 1'b0, 8'h66, 1'b0);
    send(32'h11223344, 1'b0);
    idle(2, 1'b0);
    ack();

    // Completion on the exact ack cycle
    send(32'hCAFE0001, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    step(1'b1, 1'b1, 8'hBE, 1'b1);
    step(1'b1, 1'b0, 8'hEF, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    idle(3, 1'b0);
    ack();

`ifdef RX_CHKSUM_EN
    send(32'h01020407, 1'b0);
    send(32'h01020400, 1'b0);
    idle(2, 1'b0);
    ack();
`endif

    // Randomized traffic with varying core behaviour
    rand_phase(800, 50);
    rand_phase(400, 10);
    rand_phase(800, 70);
    idle(4, 1'b0);
    ack();

    // Asynchronous reset in the middle of a packet with one held
    send(32'hDEADBEEF, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    step(1'b1, 1'b0, 8'h88, 1'b0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", bus.RX_Data_Valid, 0);
    chk("async_rst_data", bus.RX_Data, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ovf", ovf_cnt, 0);
    chk("async_rst_frm", frm_cnt, 0);
`ifdef RX_CHKSUM_EN
    chk("async_rst_chk", chk_cnt, 0);
`endif
    bus.link_valid = 0; bus.link_sop = 0;
    idle(2, 1'b0);
    rst_n = 1;
    send(32'h13579BDF, 1'b0);
    idle(2, 1'b0);
    ack();

    rand_phase(400, 50);
    idle(4, 1'b0);
    ack();
    ack();
    idle(2, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
